lsu_mem_master: RTL and testbench
=================================

# lsu_mem_master

Load/store initiator that sits between the RV32I execute stage and the word-organised data memory. It accepts one load or store request at a time from the core and converts it into a word-aligned memory access with byte enables. It waits for the memory acknowledge, bounded by a timeout, and then returns byte/half/word load data with sign or zero extension. Misaligned accesses, illegal funct3 encodings and timeouts are reported as errors.

## Interface
- TIMEOUT_CYCLES, 16: maximum number of cycles mem_req is held without mem_ack before the access is aborted with an error (range 1..255).
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3. Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores: 000 sb, 001 sh, 010 sw.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the relevant bits are right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  error flag, qualified by resp_valid.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write.
- mem_addr  out  32  word address, {req_addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables; 0000 on loads.
- mem_ack  in  1  access complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  memory read word.

## Operation
- FSM states and transitions:
  - IDLE → ACCESS on an accepted request that is legal and aligned.
  - IDLE → RESP on an accepted request that is misaligned or has an illegal funct3. No memory access is made.
  - ACCESS → RESP on mem_ack, or when the timeout counter reaches TIMEOUT_CYCLES.
  - RESP → IDLE unconditionally.
- A request is accepted when req_valid && req_ready. req_ready = (state == IDLE) && reset. The request fields (we, funct3, addr[1:0], wdata) are captured into registers at acceptance.
- Misalignment rules:
  - Halfword access with addr[0] = 1 is misaligned.
  - Word access with addr[1:0] ≠ 00 is misaligned.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: any value other than 000, 001, 010.
- Store lane formation:
  - sb: mem_wdata = {4{wdata[7:0]}}, mem_be = 0001 << addr[1:0].
  - sh: mem_wdata = {2{wdata[15:0]}}, mem_be = 0011 << addr[1:0].
  - sw: mem_wdata = wdata, mem_be = 1111.
- Load extraction from mem_rdata, captured on mem_ack:
  - lb/lbu: byte at lane addr[1:0], sign- or zero-extended.
  - lh/lhu: half at lane addr[1], sign- or zero-extended.
  - lw: full word.
- mem_req, mem_we, mem_addr, mem_wdata and mem_be are registered. They are stable for the entire ACCESS state and are all 0 outside it.
- Timeout counter:
  - Cleared on entry to ACCESS and increments each ACCESS cycle without mem_ack.
  - At TIMEOUT_CYCLES the FSM goes to RESP with resp_err = 1 and resp_rdata = 0.
- mem_ack is ignored outside ACCESS. A late ack after a timeout has no effect.
- Reset values: all outputs 0 except req_ready, which goes to 1 in the first cycle after reset deasserts. State = IDLE, counter = 0.

## Timing
- Accept at edge T (IDLE). mem_req is high from cycle T+1.
- Zero-wait memory (mem_ack high in cycle T+1): resp_valid in cycle T+2. Total latency is 2 cycles.
- N wait cycles add N cycles. Back-to-back throughput is one access per 3 cycles with zero-wait memory.
- Error without memory access: resp_valid in cycle T+1.
- Timeout: mem_req stays high for exactly TIMEOUT_CYCLES cycles. resp_valid (with error) follows in the next cycle.
- resp_valid is a single cycle with no backpressure. The core must sample it.
- Reset asserted mid-access: mem_req drops at the same edge, no resp_valid is produced, and the in-flight request is lost.
- If req_valid and reset are low at the same edge, reset wins and the request is not accepted.

## Test plan
- Load, zero-wait memory: lb from addr 0x0000_0013, mem_rdata = 0x80FF_7F01 in cycle T+1. Required: mem_addr = 0x10, mem_be = 0000, resp_rdata = 0xFFFF_FF80 at T+2. Repeat as lbu: resp_rdata = 0x0000_0080.
- Store lanes: sh to 0x0000_0022 with wdata 0x1234_ABCD. Required: mem_we = 1, mem_addr = 0x20, mem_be = 1100, mem_wdata = 0xABCD_ABCD. On ack, resp_valid with resp_rdata = 0 and resp_err = 0.
- Misaligned access: lw at 0x0000_0006. Required: mem_req never rises, resp_valid at T+1 with resp_err = 1 and resp_rdata = 0. Repeat with illegal funct3 (load funct3 = 011): same response.
- Wait states and timeout with TIMEOUT_CYCLES = 4:
  - Ack after 3 wait cycles: lw data returned, resp_err = 0.
  - No ack: mem_req high for 4 cycles, then resp_err = 1.
  - A late ack injected 2 cycles after the timeout must produce no response.
- Reset mid-access: reset low during the 2nd ACCESS cycle. Required: mem_req = 0 after that edge, no resp_valid, req_ready = 1 in the first cycle after reset is released, and a subsequent lw completes normally.
- Handshake: req_valid held high continuously. Required: req_ready is low during ACCESS and RESP, exactly one acceptance per transaction, and request fields changing after acceptance do not affect mem_addr or mem_wdata.

Source files
------------

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: RV32I load/store initiator.
// Accepts one core request at a time, issues a word-aligned memory access with
// byte enables, waits for mem_ack (bounded by a timeout) and returns a one-cycle
// response carrying extended load data or an error flag.
module lsu_mem_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Counter value in the last ACCESS cycle before the access is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;

    logic        req_bad;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    // A request is only taken while idle and out of reset.
    assign req_ready = (state == IDLE) && reset;

    // Classify the incoming request and build its store lanes.
    // NOTE: every signal gets a default at the top of an always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
        req_bad  = 1'b0;
        st_wdata = 32'd0;
        st_be    = 4'b0000;
        if (req_we) begin
            if (req_funct3 > 3'b010) req_bad = 1'b1;
        end else begin
            if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11) req_bad = 1'b1;
        end
        if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_bad = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_bad = 1'b1;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    st_wdata = {4{req_wdata[7:0]}};
                    st_be    = 4'b0001 << req_addr[1:0];
                end
                2'b01: begin
                    st_wdata = {2{req_wdata[15:0]}};
                    st_be    = 4'b0011 << req_addr[1:0];
                end
                default: begin
                    st_wdata = req_wdata;
                    st_be    = 4'b1111;
                end
            endcase
        end
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        case (addr_lo_q)
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_data = {24'd0, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = mem_rdata;
        endcase
    end

    // Request/access/response FSM with registered memory and response outputs.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            funct3_q   <= 3'd0;
            addr_lo_q  <= 2'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_be     <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        funct3_q  <= req_funct3;
                        addr_lo_q <= req_addr[1:0];
                        if (req_bad) begin
                            // Rejected without touching memory.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            state     <= ACCESS;
                            cnt       <= 8'd0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= st_wdata;
                            mem_be    <= st_be;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack || cnt == CNT_LAST) begin
                        // An ack in the final allowed cycle still completes normally.
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= !mem_ack;
                        resp_rdata <= (mem_ack && !mem_we) ? load_data : 32'd0;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_addr   <= 32'd0;
                        mem_wdata  <= 32'd0;
                        mem_be     <= 4'b0000;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master with a response scoreboard.
// Expected responses (data, error, arrival cycle) are queued when a request is
// accepted and compared when resp_valid is seen.
module tb_lsu_mem_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cnt  = 0;

    lsu_mem_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Response monitor: pop the oldest expectation on every resp_valid.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                check("resp_cycle", cyc, e.cyc);
            end
        end
    end

    // Drive one request; lat is the cycle (counting the cycle after the accept
    // edge as 1) in which resp_valid is expected.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit push,
                        input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < 8 && !req_ready; k++) @(negedge clk);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (push) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.cyc   = cyc + lat - 1;
            sbq.push_back(e);
        end
    endtask

    // Play the memory: hold off ack for 'waits' cycles, checking the bus each cycle.
    task automatic mem_serve(input int waits, input logic [31:0] rdata, input logic we,
                             input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            check("mem_req", {31'd0, mem_req}, 32'd1);
            check("mem_we", {31'd0, mem_we}, {31'd0, we});
            check("mem_addr", mem_addr, a);
            check("mem_be", {28'd0, mem_be}, {28'd0, be});
            check("mem_wdata", mem_wdata, wd);
            check("req_ready_busy", {31'd0, req_ready}, 32'd0);
            if (i == waits) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end else begin
                mem_rdata = $urandom;
            end
        end
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h5A5A_A5A5;
    endtask

    task automatic expect_no_mem(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("mem_req_quiet", {31'd0, mem_req}, 32'd0);
        end
    endtask

    initial begin
        int a0;
        exp_t e;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;

        // Reset: outputs quiet, and a request presented during reset is not taken.
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        req_valid  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        @(posedge clk);
        #1;
        check("rst_no_accept", acc_cnt, 0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_release_ready", {31'd0, req_ready}, 32'd1);
        check("rst_release_mem_req", {31'd0, mem_req}, 32'd0);

        // Loads with zero-wait memory and lane extraction.
        send(1'b0, 3'b000, 32'h13, 32'd0, 1'b1, 32'hFFFF_FF80, 1'b0, 2);
        mem_serve(0, 32'h80FF_7F01, 1'b0, 32'h10, 4'b0000, 32'd0);
        send(1'b0, 3'b100, 32'h13, 32'd0, 1'b1, 32'h0000_0080, 1'b0, 2);
        mem_serve(0, 32'h80FF_7F01, 1'b0, 32'h10, 4'b0000, 32'd0);
        send(1'b0, 3'b000, 32'h11, 32'd0, 1'b1, 32'h0000_007F, 1'b0, 2);
        mem_serve(0, 32'h80FF_7F01, 1'b0, 32'h10, 4'b0000, 32'd0);
        send(1'b0, 3'b001, 32'h12, 32'd0, 1'b1, 32'hFFFF_80FF, 1'b0, 2);
        mem_serve(0, 32'h80FF_7F01, 1'b0, 32'h10, 4'b0000, 32'd0);
        send(1'b0, 3'b101, 32'h10, 32'd0, 1'b1, 32'h0000_7F01, 1'b0, 2);
        mem_serve(0, 32'h80FF_7F01, 1'b0, 32'h10, 4'b0000, 32'd0);

        // Stores: lane replication and byte enables.
        send(1'b1, 3'b001, 32'h22, 32'h1234_ABCD, 1'b1, 32'd0, 1'b0, 2);
        mem_serve(0, 32'hFFFF_FFFF, 1'b1, 32'h20, 4'b1100, 32'hABCD_ABCD);
        send(1'b1, 3'b000, 32'h21, 32'hFFFF_FF55, 1'b1, 32'd0, 1'b0, 2);
        mem_serve(0, 32'hFFFF_FFFF, 1'b1, 32'h20, 4'b0010, 32'h5555_5555);
        send(1'b1, 3'b010, 32'h24, 32'hCAFE_F00D, 1'b1, 32'd0, 1'b0, 2);
        mem_serve(0, 32'hFFFF_FFFF, 1'b1, 32'h24, 4'b1111, 32'hCAFE_F00D);

        // Errors without a memory access.
        send(1'b0, 3'b010, 32'h06, 32'd0, 1'b1, 32'd0, 1'b1, 1);
        expect_no_mem(2);
        send(1'b0, 3'b001, 32'h03, 32'd0, 1'b1, 32'd0, 1'b1, 1);
        expect_no_mem(2);
        send(1'b0, 3'b011, 32'h00, 32'd0, 1'b1, 32'd0, 1'b1, 1);
        expect_no_mem(2);
        send(1'b0, 3'b110, 32'h00, 32'd0, 1'b1, 32'd0, 1'b1, 1);
        expect_no_mem(2);
        send(1'b1, 3'b100, 32'h00, 32'h1, 1'b1, 32'd0, 1'b1, 1);
        expect_no_mem(2);

        // Wait states: ack after 3 wait cycles.
        send(1'b0, 3'b010, 32'h10, 32'd0, 1'b1, 32'h80FF_7F01, 1'b0, 5);
        mem_serve(3, 32'h80FF_7F01, 1'b0, 32'h10, 4'b0000, 32'd0);

        // Timeout, then a late ack that must be ignored.
        send(1'b0, 3'b010, 32'h40, 32'd0, 1'b1, 32'd0, 1'b1, TO + 1);
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            check("to_mem_req_high", {31'd0, mem_req}, 32'd1);
        end
        @(negedge clk);
        check("to_mem_req_drop", {31'd0, mem_req}, 32'd0);
        repeat (2) @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        expect_no_mem(3);
        check("to_late_ack_sb", sbq.size(), 0);

        // Reset during the second ACCESS cycle: request lost, no response.
        send(1'b0, 3'b010, 32'h80, 32'd0, 1'b0, 32'd0, 1'b0, 0);
        @(negedge clk);
        check("mr_mem_req_1st", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mr_mem_req_drop", {31'd0, mem_req}, 32'd0);
        check("mr_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mr_ready_after", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        send(1'b0, 3'b010, 32'h84, 32'd0, 1'b1, 32'h1122_3344, 1'b0, 2);
        mem_serve(0, 32'h1122_3344, 1'b0, 32'h84, 4'b0000, 32'd0);

        // Handshake with req_valid held high across two transactions.
        @(negedge clk);
        for (int k = 0; k < 8 && !req_ready; k++) @(negedge clk);
        a0         = acc_cnt;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h100;
        req_wdata  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        e.rdata = 32'd0; e.err = 1'b0; e.cyc = cyc + 1;
        sbq.push_back(e);
        req_addr  = 32'h200;
        req_wdata = 32'h0BAD_F00D;
        @(negedge clk);
        check("hs_ready_access", {31'd0, req_ready}, 32'd0);
        check("hs_mem_addr", mem_addr, 32'h100);
        check("hs_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("hs_ready_resp", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        e.rdata = 32'd0; e.err = 1'b0; e.cyc = cyc + 1;
        sbq.push_back(e);
        req_valid = 1'b0;
        check("hs_accept_count", acc_cnt - a0, 2);
        mem_serve(0, 32'd0, 1'b1, 32'h200, 4'b1111, 32'h0BAD_F00D);
        repeat (3) @(negedge clk);
        check("hs_accept_final", acc_cnt - a0, 2);

        check("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
